// File: rtl/tdc_tsfifo_pkg.sv
// Shared constants for the TDC timestamp FIFO: register map, field positions
// and the derived entry width.
package tdc_tsfifo_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_TS_HI  = 2'd2;
  localparam logic [1:0] ADDR_TS_LO  = 2'd3;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;
  localparam int STAT_DROP_LSB  = 24;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_THR_LSB   = 8;
  localparam int CTRL_CLR_BIT   = 30;
  localparam int CTRL_FLUSH_BIT = 31;

  // A single channel still needs a one-bit index field.
  function automatic int chan_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

  function automatic int entry_width(input int ts_w, input int count);
    return ts_w + 1 + chan_width(count);
  endfunction

endpackage

// File: rtl/tdc_sfifo.sv
// Generic single-clock FIFO with distributed-RAM storage, asynchronous head
// read, level/full/empty status and a synchronous flush.
module tdc_sfifo #(
  parameter int g_WIDTH      = 40,
  parameter int g_DEPTH_LOG2 = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    push_i,
  input  logic [g_WIDTH-1:0]      data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [g_WIDTH-1:0]      data_o,
  output logic [g_DEPTH_LOG2:0]   level_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int DEPTH = 2 ** g_DEPTH_LOG2;

  logic [g_WIDTH-1:0]      mem_q [DEPTH];
  logic [g_DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [g_DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [g_DEPTH_LOG2:0]   level_q, level_d;
  logic                    wr_en, rd_en;

  // Level never exceeds DEPTH, so its MSB alone marks full.
  assign full_o  = level_q[g_DEPTH_LOG2];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    rd_en   = pop_i && !empty_o;
    wr_en   = push_i && (!full_o || rd_en);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + (g_DEPTH_LOG2)'(1);
      if (rd_en) rptr_d = rptr_q + (g_DEPTH_LOG2)'(1);
      if (wr_en && !rd_en)      level_d = level_q + (g_DEPTH_LOG2 + 1)'(1);
      else if (rd_en && !wr_en) level_d = level_q - (g_DEPTH_LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/tdc_tsfifo.sv
// TDC timestamp buffer: event intake into a FIFO, Wishbone register window for
// draining it, drop accounting and a level/overflow interrupt.
module tdc_tsfifo
  import tdc_tsfifo_pkg::*;
#(
  parameter int g_CHANNEL_COUNT = 2,
  parameter int g_TS_WIDTH      = 38,
  parameter int g_DEPTH_LOG2    = 5
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  ev_valid_i,
  input  logic [chan_width(g_CHANNEL_COUNT)-1:0] ev_chan_i,
  input  logic                                  ev_pol_i,
  input  logic [g_TS_WIDTH-1:0]                 ev_ts_i,
  input  logic [1:0]                            wb_addr_i,
  input  logic [31:0]                           wb_data_i,
  output logic [31:0]                           wb_data_o,
  input  logic                                  wb_cyc_i,
  input  logic                                  wb_stb_i,
  input  logic                                  wb_we_i,
  output logic                                  wb_ack_o,
  output logic                                  irq_o
);

  localparam int CW = chan_width(g_CHANNEL_COUNT);
  localparam int EW = entry_width(g_TS_WIDTH, g_CHANNEL_COUNT);

  logic                  en_q, en_d;
  logic [7:0]            thr_q, thr_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drops_q, drops_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;

  logic [EW-1:0]         head;
  logic [g_DEPTH_LOG2:0] level;
  logic                  full, empty;
  logic                  bus_req, wr_ctrl, pop, flush, push_req, drop;
  logic [g_TS_WIDTH-1:0] head_ts;
  logic                  head_pol;
  logic [CW-1:0]         head_chan;
  logic [23:0]           ts_hi;
  logic [5:0]            chan6;
  logic [8:0]            level9;
  logic [31:0]           status_w, ctrl_w, tshi_w;
  logic                  unused_wb_bits;

  assign unused_wb_bits = ^{wb_data_i[29:16], wb_data_i[7:1]};
  assign {head_pol, head_chan, head_ts} = head;

  // Accesses act on the edge that raises ack, so their effect is visible in the ack cycle.
  always_comb begin
    bus_req  = wb_cyc_i && wb_stb_i && !ack_q;
    wr_ctrl  = bus_req && wb_we_i && (wb_addr_i == ADDR_CTRL);
    pop      = bus_req && !wb_we_i && (wb_addr_i == ADDR_TS_LO);
    flush    = wr_ctrl && wb_data_i[CTRL_FLUSH_BIT];
    push_req = ev_valid_i && en_q;
    drop     = push_req && full && !pop;
  end

  tdc_sfifo #(
    .g_WIDTH      (EW),
    .g_DEPTH_LOG2 (g_DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_req),
    .data_i  ({ev_pol_i, ev_chan_i, ev_ts_i}),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    level9 = '0;
    level9[g_DEPTH_LOG2:0] = level;
    chan6 = '0;
    chan6[CW-1:0] = head_chan;
    ts_hi = '0;
    ts_hi[g_TS_WIDTH-33:0] = head_ts[g_TS_WIDTH-1:32];

    status_w = '0;
    status_w[8:0]                = level9;
    status_w[STAT_EMPTY_BIT]     = empty;
    status_w[STAT_FULL_BIT]      = full;
    status_w[STAT_OVF_BIT]       = ovf_q;
    status_w[STAT_DROP_LSB +: 8] = drops_q;

    ctrl_w = '0;
    ctrl_w[CTRL_EN_BIT]       = en_q;
    ctrl_w[CTRL_THR_LSB +: 8] = thr_q;

    // Stale RAM contents are hidden while the FIFO is empty.
    tshi_w = empty ? '0 : {1'b1, head_pol, chan6, ts_hi};
  end

  always_comb begin
    en_d    = en_q;
    thr_d   = thr_q;
    ovf_d   = ovf_q;
    drops_d = drops_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
    end
    if (wr_ctrl) begin
      en_d  = wb_data_i[CTRL_EN_BIT];
      thr_d = wb_data_i[CTRL_THR_LSB +: 8];
      if (wb_data_i[CTRL_CLR_BIT]) begin
        ovf_d   = 1'b0;
        drops_d = '0;
      end
    end

    ack_d   = bus_req;
    rdata_d = '0;
    if (bus_req && !wb_we_i) begin
      case (wb_addr_i)
        ADDR_STATUS: rdata_d = status_w;
        ADDR_CTRL:   rdata_d = ctrl_w;
        ADDR_TS_HI:  rdata_d = tshi_w;
        ADDR_TS_LO:  rdata_d = empty ? '0 : head_ts[31:0];
        default:     rdata_d = '0;
      endcase
    end

    irq_d = ((thr_q != 8'd0) && (level9 >= {1'b0, thr_q})) || ovf_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q    <= 1'b0;
      thr_q   <= '0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      thr_q   <= thr_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign wb_data_o = rdata_q;
  assign wb_ack_o  = ack_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_tdc_tsfifo.sv
// Randomized bench for tdc_tsfifo against a queue-based model of the buffer,
// its register window and the interrupt rule.
module tb_tdc_tsfifo;

  localparam int TSW   = 38;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            ev_valid = 1'b0;
  logic [0:0]      ev_chan = '0;
  logic            ev_pol = 1'b0;
  logic [TSW-1:0]  ev_ts = '0;
  logic [1:0]      wb_addr = '0;
  logic [31:0]     wb_wdat = '0;
  logic [31:0]     wb_rdat;
  logic            wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic            wb_ack, irq;

  always #5 clk = ~clk;

  tdc_tsfifo #(
    .g_CHANNEL_COUNT (2),
    .g_TS_WIDTH      (TSW),
    .g_DEPTH_LOG2    (5)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ev_valid_i (ev_valid),
    .ev_chan_i  (ev_chan),
    .ev_pol_i   (ev_pol),
    .ev_ts_i    (ev_ts),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_wdat),
    .wb_data_o  (wb_rdat),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_we_i    (wb_we),
    .wb_ack_o   (wb_ack),
    .irq_o      (irq)
  );

  typedef struct packed {
    logic           pol;
    logic [0:0]     ch;
    logic [TSW-1:0] ts;
  } ev_t;

  ev_t q[$];
  bit  m_en;
  int  m_thr;
  bit  m_ovf;
  int  m_drops;
  int  total = 0;
  int  bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    m_en = 0; m_thr = 0; m_ovf = 0; m_drops = 0;
  endfunction

  function automatic logic [31:0] m_status();
    return {8'(m_drops), 5'b0, m_ovf, q.size() == DEPTH, q.size() == 0, 7'b0, 9'(q.size())};
  endfunction

  function automatic logic [31:0] m_tshi();
    if (q.size() == 0) return 32'd0;
    return {1'b1, q[0].pol, 5'b0, q[0].ch, 18'b0, q[0].ts[TSW-1:32]};
  endfunction

  function automatic logic m_irq();
    return ((m_thr != 0) && (q.size() >= m_thr)) || m_ovf;
  endfunction

  // An event is stored whenever there is room after any same-cycle pop.
  function automatic void m_event(input ev_t e);
    if (!m_en) return;
    if (q.size() < DEPTH) q.push_back(e);
    else begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
  endfunction

  function automatic logic [31:0] m_access(input bit we, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    if (we) begin
      if (a == 2'd1) begin
        m_en  = d[0];
        m_thr = int'(d[15:8]);
        if (d[30]) begin m_ovf = 0; m_drops = 0; end
        if (d[31]) q.delete();
      end
    end else begin
      case (a)
        2'd0: r = m_status();
        2'd1: r = {16'b0, 8'(m_thr), 7'b0, m_en};
        2'd2: r = m_tshi();
        default: if (q.size() > 0) begin r = q[0].ts[31:0]; void'(q.pop_front()); end
      endcase
    end
    return r;
  endfunction

  function automatic ev_t rand_ev();
    ev_t e;
    e.pol = 1'($urandom);
    e.ch  = 1'($urandom);
    e.ts  = {6'($urandom), 32'($urandom)};
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ev_push(input ev_t e);
    @(negedge clk);
    ev_valid = 1'b1; ev_pol = e.pol; ev_chan = e.ch; ev_ts = e.ts;
    @(posedge clk);
    m_event(e);
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  task automatic bus_op(input bit we, input logic [1:0] a, input logic [31:0] d,
                        input bit ev, input ev_t e, input string tag);
    logic [31:0] exp;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_wdat = d;
    ev_valid = ev; ev_pol = e.pol; ev_chan = e.ch; ev_ts = e.ts;
    @(posedge clk);
    exp = m_access(we, a, d);
    if (ev) m_event(e);
    @(negedge clk);
    check({tag, "_ack"}, 32'(wb_ack), 32'd1);
    if (!we) check(tag, wb_rdat, exp);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; ev_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string tag);
    bus_op(1'b0, a, 32'd0, 1'b0, ev_t'(0), tag);
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    bus_op(1'b1, 2'd1, d, 1'b0, ev_t'(0), "wr_ctrl");
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) begin
      rd(2'd2, {tag, "_hi"});
      rd(2'd3, {tag, "_lo"});
    end
  endtask

  task automatic check_irq(input string tag);
    idle(1);
    check(tag, 32'(irq), 32'(m_irq()));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ev_t e;
    m_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_data", wb_rdat, 32'd0);
    rst_n = 1'b1;
    idle(1);

    rd(2'd0, "rst_status");
    check("rst_status_const", m_status(), 32'h0001_0000);
    rd(2'd3, "rst_tslo");
    rd(2'd1, "rst_ctrl");
    rd(2'd2, "rst_tshi");

    // Threshold interrupt and head formatting.
    wr_ctrl(32'h0000_0301);
    e.pol = 1'b1; e.ch = 1'b1;
    e.ts = 38'h15_0000_0001; ev_push(e);
    e.ts = 38'h00_0000_0002; ev_push(e);
    e.ts = 38'h00_0000_0003; ev_push(e);
    check("irq_latency_lo", 32'(irq), 32'd0);
    idle(1);
    check("irq_latency_hi", 32'(irq), 32'd1);
    rd(2'd2, "dir_tshi");
    check("dir_tshi_const", m_tshi(), 32'hC100_0015);
    rd(2'd3, "dir_tslo");
    rd(2'd0, "dir_status");
    check_irq("dir_irq_after_pop");
    drain("dir_drain");

    // Overflow and drop accounting.
    for (int i = 0; i < DEPTH + 3; i++) ev_push(rand_ev());
    rd(2'd0, "ovf_status");
    check_irq("ovf_irq");
    drain("ovf_drain");
    wr_ctrl(32'h4000_0301);
    rd(2'd0, "ovf_clr_status");
    check_irq("ovf_clr_irq");

    // Pop and push in the same cycle while full.
    for (int i = 0; i < DEPTH; i++) ev_push(rand_ev());
    bus_op(1'b0, 2'd3, 32'd0, 1'b1, rand_ev(), "full_popush");
    rd(2'd0, "full_popush_status");
    drain("full_popush_drain");

    // Flush leaves enable and overflow alone.
    for (int i = 0; i < DEPTH + 1; i++) ev_push(rand_ev());
    for (int i = 0; i < DEPTH - 5; i++) rd(2'd3, "pre_flush_pop");
    rd(2'd0, "pre_flush_status");
    wr_ctrl(32'h8000_0001);
    rd(2'd0, "flush_status");
    rd(2'd1, "flush_ctrl");

    // Disabled intake ignores events without counting drops.
    wr_ctrl(32'h4000_0000);
    for (int i = 0; i < 10; i++) ev_push(rand_ev());
    rd(2'd0, "dis_status");
    check_irq("dis_irq");

    // Randomized mix of events and register accesses.
    wr_ctrl({16'b0, 8'($urandom_range(1, 34)), 7'b0, 1'b1});
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: ev_push(rand_ev());
        4, 5: bus_op(1'b0, 2'd3, 32'd0, 1'($urandom), rand_ev(), "rnd_tslo");
        6: rd(2'd2, "rnd_tshi");
        7: rd(2'd0, "rnd_status");
        8: idle(1);
        default: begin
          if ($urandom_range(0, 3) == 0)
            wr_ctrl({1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 14'b0,
                     8'($urandom_range(0, 34)), 7'b0, 1'($urandom_range(0, 4) != 0)});
          else
            rd(2'd1, "rnd_ctrl");
        end
      endcase
      if (i % 8 == 0) check_irq("rnd_irq");
    end
    rd(2'd0, "rnd_final_status");

    // Reset asserted while a TS_LO read is being acknowledged.
    wr_ctrl(32'h4000_0101);
    for (int i = 0; i < 4; i++) ev_push(rand_ev());
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 2'd3;
    @(posedge clk);
    #1;
    check("mid_rst_pre_ack", 32'(wb_ack), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(wb_ack), 32'd0);
    check("mid_rst_data", wb_rdat, 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    rd(2'd0, "post_rst_status");
    rd(2'd1, "post_rst_ctrl");
    rd(2'd3, "post_rst_tslo");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
